// File: rtl/retire_mon_pkg.sv
// rtl/retire_mon_pkg.sv - shared state encoding and lane-acceptance helpers for retire_monitor
package retire_mon_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE, HANG} mon_state_t;

  // Helpers work on a fixed maximum lane count; callers zero-extend narrower vectors.
  localparam int MAX_LANES = 8;
  typedef logic [MAX_LANES-1:0] lane_vec_t;

  // Valid lanes up to and including the oldest halting lane.
  function automatic lane_vec_t accept_mask(input lane_vec_t valid, input lane_vec_t halt);
    lane_vec_t m;
    logic      stop;
    m    = '0;
    stop = 1'b0;
    for (int i = 0; i < MAX_LANES; i++) begin
      if (!stop && valid[i]) begin
        m[i] = 1'b1;
        if (halt[i]) stop = 1'b1;
      end
    end
    return m;
  endfunction

  // Number of lanes accept_mask would take.
  function automatic logic [3:0] popcount_upto_halt(input lane_vec_t valid, input lane_vec_t halt);
    lane_vec_t  m;
    logic [3:0] n;
    m = accept_mask(valid, halt);
    n = '0;
    for (int i = 0; i < MAX_LANES; i++) n = n + 4'(m[i]);
    return n;
  endfunction

endpackage

// File: rtl/retire_hist_buf.sv
// rtl/retire_hist_buf.sv - circular history buffer with N masked write lanes and one combinational read port
module retire_hist_buf #(
  parameter int N     = 2,
  parameter int W     = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     wr_en,
  input  logic [N-1:0]             wr_mask,
  input  logic [N*W-1:0]           wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_idx,
  output logic [W-1:0]             rd_data,
  output logic                     rd_valid
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic [AW-1:0] slot [N];
  logic [AW:0]   n_wr;
  logic [AW+1:0] cnt_sum;

  // Masked lanes pack densely: each lane lands after the masked lanes below it.
  always_comb begin
    n_wr = '0;
    for (int i = 0; i < N; i++) begin
      slot[i] = wr_ptr + n_wr[AW-1:0];
      n_wr    = n_wr + (AW+1)'(wr_mask[i]);
    end
  end

  assign cnt_sum = {1'b0, count} + {1'b0, n_wr};

  // Entry storage; not reset, reads beyond count return stale data.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < N; i++) begin
        if (wr_mask[i]) mem[slot[i]] <= wr_data[i*W +: W];
      end
    end
  end

  // Write pointer wraps modulo DEPTH; fill count saturates at DEPTH.
  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      wr_ptr <= '0;
      count  <= '0;
    end else if (wr_en) begin
      wr_ptr <= wr_ptr + n_wr[AW-1:0];
      count  <= (cnt_sum > (AW+2)'(DEPTH)) ? (AW+1)'(DEPTH) : cnt_sum[AW:0];
    end
  end

  assign rd_data  = mem[wr_ptr - AW'(1) - rd_idx];
  assign rd_valid = ({1'b0, rd_idx} < count);

endmodule

// File: rtl/retire_monitor.sv
// rtl/retire_monitor.sv - commit-stage monitor (counters, halt/hang detection, PC history); optional checker via RETIRE_MON_PCHK_EN
module retire_monitor
  import retire_mon_pkg::*;
#(
  parameter int RETIRE_W   = 2,
  parameter int PC_W       = 32,
  parameter int HIST_DEPTH = 8,
  parameter int WDOG_W     = 16,
  parameter int CNT_W      = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          arm,
  input  logic                          clear,
  input  logic [WDOG_W-1:0]             cfg_timeout,
  input  logic [RETIRE_W-1:0]           retire_valid,
  input  logic [RETIRE_W*PC_W-1:0]      retire_pc,
  input  logic [RETIRE_W-1:0]           retire_is_halt,
  input  logic [$clog2(HIST_DEPTH)-1:0] hist_rd_idx,
  output logic [PC_W-1:0]               hist_rd_pc,
  output logic                          hist_rd_valid,
  output logic                          running,
  output logic                          done,
  output logic                          hang,
  output logic [CNT_W-1:0]              cycle_count,
  output logic [CNT_W-1:0]              retired_count,
  output logic [PC_W-1:0]               last_pc,
  output logic                          proto_err
);

  mon_state_t          state, state_next;
  lane_vec_t           valid_ext, halt_ext, acc_ext;
  logic [RETIRE_W-1:0] acc;
  logic [3:0]          n_acc;
  logic                halt_acc;
  logic                wdog_expire;
  logic [WDOG_W-1:0]   wdog;
  logic [CNT_W:0]      ret_sum;
  logic [PC_W-1:0]     last_pc_next;
  logic                unused_acc_bits;

  // Lane acceptance: widen to the helper width, keep only the real lanes.
  always_comb begin
    valid_ext                 = '0;
    halt_ext                  = '0;
    valid_ext[RETIRE_W-1:0]   = retire_valid;
    halt_ext[RETIRE_W-1:0]    = retire_is_halt;
    acc_ext                   = accept_mask(valid_ext, halt_ext);
    n_acc                     = popcount_upto_halt(valid_ext, halt_ext);
    acc                       = acc_ext[RETIRE_W-1:0];
    halt_acc                  = |(acc & retire_is_halt);
    last_pc_next              = last_pc;
    for (int i = 0; i < RETIRE_W; i++) begin
      if (acc[i]) last_pc_next = retire_pc[i*PC_W +: PC_W];
    end
  end

  assign unused_acc_bits = ^acc_ext;
  assign ret_sum         = {1'b0, retired_count} + (CNT_W+1)'(n_acc);
  assign wdog_expire     = (cfg_timeout != '0) && (n_acc == '0) && (wdog == cfg_timeout - WDOG_W'(1));

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next state: clear wins; a halt in the timeout cycle means DONE.
  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (arm) state_next = RUN;
        RUN:     if (halt_acc) state_next = DONE;
                 else if (wdog_expire) state_next = HANG;
        default: state_next = state;
      endcase
    end
  end

  // Counters, watchdog and last PC advance only while running; frozen otherwise.
  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      cycle_count   <= '0;
      retired_count <= '0;
      last_pc       <= '0;
      wdog          <= '0;
    end else if (state == RUN) begin
      if (cycle_count != '1) cycle_count <= cycle_count + CNT_W'(1);
      retired_count <= ret_sum[CNT_W] ? '1 : ret_sum[CNT_W-1:0];
      last_pc       <= last_pc_next;
      if (n_acc != '0 || cfg_timeout == '0) wdog <= '0;
      else                                   wdog <= wdog + WDOG_W'(1);
    end
  end

  assign running = (state == RUN);
  assign done    = (state == DONE);
  assign hang    = (state == HANG);

  retire_hist_buf #(
    .N     (RETIRE_W),
    .W     (PC_W),
    .DEPTH (HIST_DEPTH)
  ) u_hist (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .wr_en    ((state == RUN) && !clear),
    .wr_mask  (acc),
    .wr_data  (retire_pc),
    .rd_idx   (hist_rd_idx),
    .rd_data  (hist_rd_pc),
    .rd_valid (hist_rd_valid)
  );

`ifdef RETIRE_MON_PCHK_EN
  logic proto_hit;
  logic proto_err_q;

  // Gaps in the valid vector while running, or any retire outside RUN.
  assign proto_hit = (state == RUN) ? ((retire_valid & (retire_valid + RETIRE_W'(1))) != '0)
                                    : (retire_valid != '0);

  // Sticky error flag, dropped only by reset or clear.
  always_ff @(posedge clk) begin
    if (!reset || clear)  proto_err_q <= 1'b0;
    else if (proto_hit)   proto_err_q <= 1'b1;
  end

`ifndef SYNTHESIS
  // Report the first occurrence only.
  always_ff @(posedge clk) begin
    if (reset && !clear && proto_hit && !proto_err_q)
      $error("retire_monitor: retire protocol error, state=%0d valid=%b", state, retire_valid);
  end
`endif

  assign proto_err = proto_err_q;
`else
  assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_retire_monitor.sv
// tb/tb_retire_monitor.sv - self-checking bench for retire_monitor with a queue-based reference model
module tb_retire_monitor;

  localparam int S_IDLE = 0, S_RUN = 1, S_DONE = 2, S_HANG = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        arm = 1'b0;
  logic        clear = 1'b0;
  logic [15:0] cfg_timeout = '0;
  logic [1:0]  retire_valid = '0;
  logic [63:0] retire_pc = '0;
  logic [1:0]  retire_is_halt = '0;
  logic [2:0]  hist_rd_idx = '0;
  logic [31:0] hist_rd_pc;
  logic        hist_rd_valid;
  logic        running, done, hang;
  logic [31:0] cycle_count, retired_count, last_pc;
  logic        proto_err;

  always #5 clk = ~clk;

  retire_monitor dut (
    .clk            (clk),
    .reset          (reset),
    .arm            (arm),
    .clear          (clear),
    .cfg_timeout    (cfg_timeout),
    .retire_valid   (retire_valid),
    .retire_pc      (retire_pc),
    .retire_is_halt (retire_is_halt),
    .hist_rd_idx    (hist_rd_idx),
    .hist_rd_pc     (hist_rd_pc),
    .hist_rd_valid  (hist_rd_valid),
    .running        (running),
    .done           (done),
    .hang           (hang),
    .cycle_count    (cycle_count),
    .retired_count  (retired_count),
    .last_pc        (last_pc),
    .proto_err      (proto_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: newest PC at the front of the queue.
  int          m_state = S_IDLE;
  logic [31:0] m_cyc = '0, m_ret = '0, m_last = '0;
  int          m_wd = 0;
  bit          m_perr = 1'b0;
  logic [31:0] m_hist[$];

  task automatic model_step();
    int          n;
    bit          halted;
    logic [31:0] pc;
    if (!reset || clear) begin
      m_state = S_IDLE; m_cyc = '0; m_ret = '0; m_last = '0; m_wd = 0; m_perr = 1'b0;
      m_hist.delete();
    end else begin
`ifdef RETIRE_MON_PCHK_EN
      if (m_state == S_RUN) begin
        if (retire_valid == 2'b10) m_perr = 1'b1;
      end else if (retire_valid != 2'b00) m_perr = 1'b1;
`endif
      case (m_state)
        S_IDLE: if (arm) m_state = S_RUN;
        S_RUN: begin
          n = 0;
          halted = 1'b0;
          if (m_cyc != 32'hFFFF_FFFF) m_cyc = m_cyc + 32'd1;
          for (int i = 0; i < 2; i++) begin
            if (!halted && retire_valid[i]) begin
              pc = retire_pc[i*32 +: 32];
              m_hist.push_front(pc);
              if (m_hist.size() > 8) void'(m_hist.pop_back());
              m_last = pc;
              n++;
              if (retire_is_halt[i]) halted = 1'b1;
            end
          end
          m_ret = m_ret + 32'(n);
          if (halted) m_state = S_DONE;
          else if (n > 0 || cfg_timeout == 16'd0) m_wd = 0;
          else if (m_wd == int'(cfg_timeout) - 1) m_state = S_HANG;
          else m_wd++;
        end
        default: ;
      endcase
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [31:0] p0, input logic [31:0] p1, input logic [1:0] h);
    retire_valid   = v;
    retire_pc      = {p1, p0};
    retire_is_halt = h;
  endtask

  task automatic restart(input logic [15:0] to);
    drive(2'b00, 0, 0, 2'b00);
    clear = 1'b1; tick(); clear = 1'b0;
    cfg_timeout = to;
    arm = 1'b1; tick(); arm = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; drive(2'b00, 0, 0, 2'b00);
    tick(); tick();
    reset = 1'b1;
    hist_rd_idx = 3'd0; #1;
    n_tests++; if ({running, done, hang} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b want 000", {running, done, hang}); end
    n_tests++; if (cycle_count !== 32'd0) begin n_fail++; $display("FAIL reset_cycle: got %0d want 0", cycle_count); end
    n_tests++; if (retired_count !== 32'd0) begin n_fail++; $display("FAIL reset_retired: got %0d want 0", retired_count); end
    n_tests++; if (last_pc !== 32'd0) begin n_fail++; $display("FAIL reset_last_pc: got %h want 0", last_pc); end
    n_tests++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL reset_proto: got %b want 0", proto_err); end
    n_tests++; if (hist_rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_hist_valid: got %b want 0", hist_rd_valid); end
  endtask

  task automatic test_single_lane();
    restart(16'd0);
    for (int k = 0; k < 10; k++) begin
      drive(2'b01, 32'(k * 4), 32'h0, 2'b00);
      tick();
    end
    drive(2'b00, 0, 0, 2'b00);
    n_tests++; if (retired_count !== 32'd10) begin n_fail++; $display("FAIL single_retired: got %0d want 10", retired_count); end
    n_tests++; if (cycle_count !== 32'd10) begin n_fail++; $display("FAIL single_cycle: got %0d want 10", cycle_count); end
    n_tests++; if (last_pc !== 32'h24) begin n_fail++; $display("FAIL single_last_pc: got %h want 24", last_pc); end
    hist_rd_idx = 3'd0; #1;
    n_tests++; if (hist_rd_pc !== 32'h24) begin n_fail++; $display("FAIL single_hist0: got %h want 24", hist_rd_pc); end
    hist_rd_idx = 3'd7; #1;
    n_tests++; if (hist_rd_pc !== 32'h08) begin n_fail++; $display("FAIL single_hist7: got %h want 08", hist_rd_pc); end
    n_tests++; if (hist_rd_valid !== 1'b1) begin n_fail++; $display("FAIL single_hist7_valid: got %b want 1", hist_rd_valid); end
  endtask

  task automatic test_dual_wrap();
    restart(16'd0);
    for (int k = 0; k < 5; k++) begin
      drive(2'b11, 32'h100 + 32'(8 * k), 32'h104 + 32'(8 * k), 2'b00);
      tick();
    end
    drive(2'b00, 0, 0, 2'b00);
    n_tests++; if (retired_count !== 32'd10) begin n_fail++; $display("FAIL dual_retired: got %0d want 10", retired_count); end
    n_tests++; if (last_pc !== 32'h124) begin n_fail++; $display("FAIL dual_last_pc: got %h want 124", last_pc); end
    hist_rd_idx = 3'd0; #1;
    n_tests++; if (hist_rd_pc !== 32'h124) begin n_fail++; $display("FAIL dual_hist0: got %h want 124", hist_rd_pc); end
    hist_rd_idx = 3'd7; #1;
    n_tests++; if (hist_rd_pc !== 32'h108) begin n_fail++; $display("FAIL dual_hist7: got %h want 108", hist_rd_pc); end
  endtask

  // Continues from the RUN state left by test_dual_wrap (10 retired, 5 cycles).
  task automatic test_halt();
    drive(2'b11, 32'h40, 32'h44, 2'b01);
    tick();
    drive(2'b00, 0, 0, 2'b00);
    n_tests++; if (retired_count !== 32'd11) begin n_fail++; $display("FAIL halt_retired: got %0d want 11", retired_count); end
    n_tests++; if (last_pc !== 32'h40) begin n_fail++; $display("FAIL halt_last_pc: got %h want 40", last_pc); end
    n_tests++; if ({running, done, hang} !== 3'b010) begin n_fail++; $display("FAIL halt_flags: got %b want 010", {running, done, hang}); end
    hist_rd_idx = 3'd0; #1;
    n_tests++; if (hist_rd_pc !== 32'h40) begin n_fail++; $display("FAIL halt_hist0: got %h want 40", hist_rd_pc); end
    for (int k = 0; k < 3; k++) begin
      drive(2'b11, 32'h500, 32'h504, 2'b00);
      arm = 1'b1;
      tick();
    end
    arm = 1'b0;
    drive(2'b00, 0, 0, 2'b00);
    n_tests++; if (retired_count !== 32'd11) begin n_fail++; $display("FAIL halt_frozen_retired: got %0d want 11", retired_count); end
    n_tests++; if (cycle_count !== 32'd6) begin n_fail++; $display("FAIL halt_frozen_cycle: got %0d want 6", cycle_count); end
    n_tests++; if (last_pc !== 32'h40) begin n_fail++; $display("FAIL halt_frozen_last_pc: got %h want 40", last_pc); end
    n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL halt_frozen_done: got %b want 1", done); end
  endtask

  task automatic test_watchdog_hang();
    restart(16'd5);
    for (int k = 0; k < 4; k++) tick();
    n_tests++; if ({running, hang} !== 2'b10) begin n_fail++; $display("FAIL wdog_early: got run/hang %b want 10", {running, hang}); end
    tick();
    n_tests++; if ({running, hang} !== 2'b01) begin n_fail++; $display("FAIL wdog_hang: got run/hang %b want 01", {running, hang}); end
  endtask

  task automatic test_halt_at_timeout();
    restart(16'd5);
    for (int k = 0; k < 4; k++) tick();
    drive(2'b01, 32'h80, 32'h0, 2'b01);
    tick();
    drive(2'b00, 0, 0, 2'b00);
    n_tests++; if ({done, hang} !== 2'b10) begin n_fail++; $display("FAIL halt_timeout_flags: got done/hang %b want 10", {done, hang}); end
    n_tests++; if (retired_count !== 32'd1) begin n_fail++; $display("FAIL halt_timeout_retired: got %0d want 1", retired_count); end
  endtask

  task automatic test_no_timeout();
    restart(16'd0);
    for (int k = 0; k < 100; k++) tick();
    n_tests++; if ({running, hang} !== 2'b10) begin n_fail++; $display("FAIL notimeout_flags: got run/hang %b want 10", {running, hang}); end
    n_tests++; if (cycle_count !== 32'd100) begin n_fail++; $display("FAIL notimeout_cycle: got %0d want 100", cycle_count); end
    reset = 1'b0; tick(); reset = 1'b1;
    hist_rd_idx = 3'd0; #1;
    n_tests++; if ({running, done, hang, proto_err, hist_rd_valid} !== 5'b0) begin n_fail++; $display("FAIL midrun_reset_flags: got %b want 00000", {running, done, hang, proto_err, hist_rd_valid}); end
    n_tests++; if (cycle_count !== 32'd0) begin n_fail++; $display("FAIL midrun_reset_cycle: got %0d want 0", cycle_count); end
  endtask

  task automatic test_proto();
    logic exp_err;
`ifdef RETIRE_MON_PCHK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    restart(16'd0);
    drive(2'b10, 32'h0, 32'h200, 2'b00);
    tick();
    drive(2'b00, 0, 0, 2'b00);
    n_tests++; if (proto_err !== exp_err) begin n_fail++; $display("FAIL proto_set: got %b want %b", proto_err, exp_err); end
    n_tests++; if (retired_count !== 32'd1) begin n_fail++; $display("FAIL proto_retired: got %0d want 1", retired_count); end
    n_tests++; if (last_pc !== 32'h200) begin n_fail++; $display("FAIL proto_last_pc: got %h want 200", last_pc); end
    clear = 1'b1; tick(); clear = 1'b0;
    n_tests++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL proto_clear: got %b want 0", proto_err); end
  endtask

  task automatic test_random();
    logic [2:0] exp_flags;
    int         idx;
    for (int c = 0; c < 500; c++) begin
      clear = ($urandom_range(0, 39) == 0);
      arm   = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 49) == 0) cfg_timeout = 16'($urandom_range(0, 6));
      drive(($urandom_range(0, 1) != 0) ? 2'($urandom_range(1, 3)) : 2'b00,
            $urandom, $urandom,
            ($urandom_range(0, 15) == 0) ? 2'($urandom_range(1, 3)) : 2'b00);
      tick();
      exp_flags = {m_state == S_RUN, m_state == S_DONE, m_state == S_HANG};
      n_tests++; if ({running, done, hang} !== exp_flags) begin n_fail++; $display("FAIL rand_flags c=%0d: got %b want %b", c, {running, done, hang}, exp_flags); end
      n_tests++; if (cycle_count !== m_cyc) begin n_fail++; $display("FAIL rand_cycle c=%0d: got %0d want %0d", c, cycle_count, m_cyc); end
      n_tests++; if (retired_count !== m_ret) begin n_fail++; $display("FAIL rand_retired c=%0d: got %0d want %0d", c, retired_count, m_ret); end
      n_tests++; if (last_pc !== m_last) begin n_fail++; $display("FAIL rand_last_pc c=%0d: got %h want %h", c, last_pc, m_last); end
      n_tests++; if (proto_err !== m_perr) begin n_fail++; $display("FAIL rand_proto c=%0d: got %b want %b", c, proto_err, m_perr); end
      idx = $urandom_range(0, 7);
      hist_rd_idx = 3'(idx); #1;
      n_tests++; if (hist_rd_valid !== (idx < m_hist.size())) begin n_fail++; $display("FAIL rand_hist_valid c=%0d idx=%0d: got %b want %b", c, idx, hist_rd_valid, idx < m_hist.size()); end
      if (idx < m_hist.size()) begin
        n_tests++; if (hist_rd_pc !== m_hist[idx]) begin n_fail++; $display("FAIL rand_hist_pc c=%0d idx=%0d: got %h want %h", c, idx, hist_rd_pc, m_hist[idx]); end
      end
    end
    clear = 1'b0; arm = 1'b0;
    drive(2'b00, 0, 0, 2'b00);
  endtask

  initial begin
    test_reset();
    test_single_lane();
    test_dual_wrap();
    test_halt();
    test_watchdog_hang();
    test_halt_at_timeout();
    test_no_timeout();
    test_proto();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "simulation time limit");
  end

endmodule
